// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Package  : systolic_pkg
// Brief    : Shared constants, FSM state encoding and helper functions for the
//            systolic matrix-multiply array, its PEs and its edge feeder.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Default array dimension and operand width
    localparam int unsigned c_N_DEFAULT  = 4;
    localparam int unsigned c_DW_DEFAULT = 8;

    // Feeder FSM states; FLUSH exists in hardware only when draining is built in
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

    // Width of the skew step counter: it must hold 0 .. 3N-3
    function automatic int unsigned step_width(input int unsigned n);
        return $clog2(3 * n);
    endfunction

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/systolic_feeder_if.sv
`default_nettype none
// ============================================================================
// Interface: systolic_feeder_if
// Brief    : Load/start/stream bundle of the systolic edge feeder. The master
//            side loads operands and starts runs; the slave side is the feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_feeder_if
    import systolic_pkg::*;
#(
    parameter int N  = c_N_DEFAULT,
    parameter int DW = c_DW_DEFAULT
) ();

    logic                   wr_en;
    logic                   wr_sel;
    logic [$clog2(N)-1:0]   wr_row;
    logic [$clog2(N)-1:0]   wr_col;
    logic [DW-1:0]          wr_data;
    logic                   start;
    logic                   busy;
    logic [N*DW-1:0]        a_o;
    logic [N*DW-1:0]        b_o;
    logic                   valid_o;
    logic                   done;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, a_o, b_o, valid_o, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, a_o, b_o, valid_o, done
    );

endinterface : systolic_feeder_if
`default_nettype wire

// File: rtl/systolic_feeder_bank.sv
`default_nettype none
// ============================================================================
// Module   : feeder_bank
// Brief    : N x N x DW operand register file with one synchronous write port
//            and N combinational diagonal read ports. Port r reads row r at
//            column (t - r) and flags whether that column lies in 0..N-1.
// Revision : 1.0 - initial release
// ============================================================================
module feeder_bank
    import systolic_pkg::*;
#(
    parameter int N  = c_N_DEFAULT,
    parameter int DW = c_DW_DEFAULT,
    parameter int TW = step_width(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [$clog2(N)-1:0]   i_wr_row,
    input  logic [$clog2(N)-1:0]   i_wr_col,
    input  logic [DW-1:0]          i_wr_data,
    input  logic [TW-1:0]          i_t,
    output logic [N*DW-1:0]        o_rd_data,
    output logic [N-1:0]           o_rd_hit
);

    localparam int c_AW = $clog2(N);

    logic [DW-1:0] r_mem [N][N];

    // Register file: cleared by reset, one element written per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_row][i_wr_col] <= i_wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_port
            localparam logic [TW-1:0] c_ROW = TW'(gi);

            logic            w_ge;
            logic [TW-1:0]   w_diff;
            logic [c_AW-1:0] w_col;

            // t - row is only formed once t >= row is known, so it never wraps
            assign w_ge   = (i_t >= c_ROW);
            assign w_diff = w_ge ? (i_t - c_ROW) : '0;
            assign w_col  = c_AW'(w_diff);

            assign o_rd_hit[gi]            = w_ge && (w_diff < TW'(N));
            assign o_rd_data[gi*DW +: DW]  = r_mem[gi][w_col];
        end
    endgenerate

endmodule : feeder_bank
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder
// Brief    : West/north edge driver of the systolic array. Holds operand
//            matrices A and B and streams them diagonally skewed, one lane per
//            array row (a) and column (b), framed by valid_o, ending with done.
// Options  : FEEDER_FLUSH_EN - adds an N-cycle FLUSH phase (lanes zero,
//            valid_o low, busy high) between the last stream step and done.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N  = c_N_DEFAULT,
    parameter int DW = c_DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    systolic_feeder_if.slave  bus
);

    localparam int c_AW = $clog2(N);
    localparam int c_TW = step_width(N);
    localparam logic [c_TW-1:0] c_LAST = c_TW'(3 * N - 3);

    localparam logic [1:0] c_S_IDLE  = ST_IDLE;
    localparam logic [1:0] c_S_FEED  = ST_FEED;
    localparam logic [1:0] c_S_DONE  = ST_DONE;
`ifdef FEEDER_FLUSH_EN
    localparam logic [1:0] c_S_FLUSH = ST_FLUSH;
    localparam logic [c_AW-1:0] c_FL_LAST = c_AW'(N - 1);
`endif

    logic [1:0]        r_state;
    logic [c_TW-1:0]   r_t;
    logic              r_busy;
    logic              r_valid;
    logic              r_done;
    logic [N*DW-1:0]   r_a;
    logic [N*DW-1:0]   r_b;

    logic              w_idle;
    logic              w_accept;
    logic              w_feed;
    logic              w_wr_a;
    logic              w_wr_b;
    logic [N*DW-1:0]   w_a_rd;
    logic [N*DW-1:0]   w_b_rd;
    logic [N-1:0]      w_a_hit;
    logic [N-1:0]      w_b_hit;
    logic [N*DW-1:0]   w_a_lane;
    logic [N*DW-1:0]   w_b_lane;

`ifdef FEEDER_FLUSH_EN
    logic [c_AW-1:0]   r_fl;
`endif

    // The done cycle is IDLE internally but still reports busy; holding off
    // writes and start until busy drops keeps the visible handshake honest.
    assign w_idle   = (r_state == c_S_IDLE) && !r_busy;
    assign w_accept = w_idle && bus.start;
    assign w_feed   = (r_state == c_S_FEED);
    assign w_wr_a   = w_idle && bus.wr_en && !bus.wr_sel;
    assign w_wr_b   = w_idle && bus.wr_en &&  bus.wr_sel;

    feeder_bank #(
        .N  (N),
        .DW (DW),
        .TW (c_TW)
    ) u_bank_a (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_a),
        .i_wr_row  (bus.wr_row),
        .i_wr_col  (bus.wr_col),
        .i_wr_data (bus.wr_data),
        .i_t       (r_t),
        .o_rd_data (w_a_rd),
        .o_rd_hit  (w_a_hit)
    );

    // B is stored transposed so that port j reads B[t-j][j] along its column
    feeder_bank #(
        .N  (N),
        .DW (DW),
        .TW (c_TW)
    ) u_bank_b (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_b),
        .i_wr_row  (bus.wr_col),
        .i_wr_col  (bus.wr_row),
        .i_wr_data (bus.wr_data),
        .i_t       (r_t),
        .o_rd_data (w_b_rd),
        .o_rd_hit  (w_b_hit)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign w_a_lane[gi*DW +: DW] = w_a_hit[gi] ? w_a_rd[gi*DW +: DW] : '0;
            assign w_b_lane[gi*DW +: DW] = w_b_hit[gi] ? w_b_rd[gi*DW +: DW] : '0;
        end
    endgenerate

`ifdef FEEDER_FLUSH_EN
    // Flush cycle counter, running only while the array drains
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fl <= '0;
        end else if (r_state == c_S_FLUSH) begin
            r_fl <= r_fl + c_AW'(1);
        end else begin
            r_fl <= '0;
        end
    end
`endif

    // Run sequencer and skew step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_t     <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_S_FEED;
                        r_t     <= '0;
                    end
                end
                c_S_FEED: begin
                    if (r_t == c_LAST) begin
`ifdef FEEDER_FLUSH_EN
                        r_state <= c_S_FLUSH;
`else
                        r_state <= c_S_DONE;
`endif
                    end else begin
                        r_t <= r_t + c_TW'(1);
                    end
                end
`ifdef FEEDER_FLUSH_EN
                c_S_FLUSH: begin
                    if (r_fl == c_FL_LAST) begin
                        r_state <= c_S_DONE;
                    end
                end
`endif
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Output registers: lanes carry data only on FEED steps, zero otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_busy  <= (r_state != c_S_IDLE);
            r_valid <= w_feed;
            r_done  <= (r_state == c_S_DONE);
            r_a     <= w_feed ? w_a_lane : '0;
            r_b     <= w_feed ? w_b_lane : '0;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.valid_o = r_valid;
    assign bus.done    = r_done;
    assign bus.a_o     = r_a;
    assign bus.b_o     = r_b;

endmodule : systolic_feeder
`default_nettype wire
